// File: rtl/ram_dp_arb_ctrl.sv
// ram_dp_arb_ctrl: round-robin arbiter and setup/strobe/hold sequencer sharing an async dual-port RAM
// between requesters A and B. Define RAM_ARB_STATS_EN to add saturating ack counters cnt_a/cnt_b.
module ram_dp_arb_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  ack_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic                  ram_cs_0,
  output logic                  ram_we_0,
  output logic                  ram_oe_0,
  output logic [ADDR_WIDTH-1:0] ram_address_1,
  output logic                  ram_cs_1,
  output logic                  ram_oe_1,
  output logic                  ram_we_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]           cnt_a,
  output logic [15:0]           cnt_b
`endif
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  last_a;      // 0 means B was granted last, so A wins the next tie
  logic                  lat_we;
  logic                  lat_id;      // 0 = A, 1 = B
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  grant;
  logic                  grant_b;
  logic                  access_done;

  assign access_done = (state == ACCESS) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant     = 1'b1;
          grant_b   = req_b && (!req_a || last_a);
          state_nxt = SETUP;
        end
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_done) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_address_0 = '0;
    ram_data_0    = '0;
    ram_address_1 = '0;
    ram_cs_0      = 1'b0;
    ram_we_0      = 1'b0;
    ram_cs_1      = 1'b0;
    ram_oe_1      = 1'b0;
    ack_a         = 1'b0;
    ack_b         = 1'b0;
    if (state != IDLE) begin
      if (lat_we) begin
        ram_address_0 = lat_addr;
        ram_data_0    = lat_wdata;
      end else begin
        ram_address_1 = lat_addr;
      end
    end
    if (state == ACCESS) begin
      ram_cs_0 = lat_we;
      ram_we_0 = lat_we;
      ram_cs_1 = !lat_we;
      ram_oe_1 = !lat_we;
    end
    if (state == HOLD) begin
      ack_a = !lat_id;
      ack_b = lat_id;
    end
  end

  assign ram_oe_0 = 1'b0;
  assign ram_we_1 = 1'b0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_a    <= 1'b0;
      lat_we    <= 1'b0;
      lat_id    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
    end else begin
      if (grant) begin
        lat_we    <= grant_b ? we_b    : we_a;
        lat_addr  <= grant_b ? addr_b  : addr_a;
        lat_wdata <= grant_b ? wdata_b : wdata_a;
        lat_id    <= grant_b;
        last_a    <= !grant_b;
      end
      if (state == SETUP)       wait_cnt <= WAIT_LOAD;
      else if (state == ACCESS) wait_cnt <= wait_cnt - WAIT_LAST;
    end
  end

  // Read data is sampled on the edge that leaves ACCESS, while oe_1 is still asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (access_done && !lat_we) begin
      if (lat_id) rdata_b <= ram_data_1;
      else        rdata_a <= ram_data_1;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] cnt_a_r;
  logic [15:0] cnt_b_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else begin
      if (ack_a && (cnt_a_r != '1)) cnt_a_r <= cnt_a_r + 16'd1;
      if (ack_b && (cnt_b_r != '1)) cnt_b_r <= cnt_b_r + 16'd1;
    end
  end

  assign cnt_a = cnt_a_r;
  assign cnt_b = cnt_b_r;
`endif

endmodule

// File: tb/tb_ram_dp_arb_ctrl.sv
// Testbench for ram_dp_arb_ctrl: random transactions against a queue/array reference model of the
// arbiter and RAM. Counter checks are included when RAM_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_ram_dp_arb_ctrl;
  localparam int          DW = 8;
  localparam int          AW = 8;
  localparam int unsigned WC = 2;

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } txn_t;
  typedef struct {
    bit          id;
    int unsigned cyc;
    logic [DW-1:0] rda;
    logic [DW-1:0] rdb;
    int unsigned wr;
    int unsigned rd;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic ack_a, ack_b, busy, ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_oe_1, ram_we_1;
  logic [DW-1:0] rdata_a, rdata_b, ram_data_0, ram_data_1;
  logic [AW-1:0] ram_address_0, ram_address_1;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  ram_dp_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .busy(busy),
    .ram_address_0(ram_address_0), .ram_data_0(ram_data_0), .ram_cs_0(ram_cs_0),
    .ram_we_0(ram_we_0), .ram_oe_0(ram_oe_0),
    .ram_address_1(ram_address_1), .ram_cs_1(ram_cs_1), .ram_oe_1(ram_oe_1),
    .ram_we_1(ram_we_1), .ram_data_1(ram_data_1)
`ifdef RAM_ARB_STATS_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int unsigned a);
    return DW'(a * 37 + 5);
  endfunction

  // Asynchronous dual-port RAM; unwritten locations read a fixed address-derived pattern
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];
  always @(posedge clk)
    if (ram_cs_0 && ram_we_0) begin
      mem[ram_address_0]     <= ram_data_0;
      written[ram_address_0] <= 1'b1;
    end
  assign ram_data_1 = !(ram_cs_1 && ram_oe_1) ? '0 :
                      written[ram_address_1] ? mem[ram_address_1] : init_val(int'(ram_address_1));

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] m_rda, m_rdb;
  bit            m_last_a;
  int unsigned   m_cnt_a, m_cnt_b;

  int unsigned checks = 0, passed = 0;
  int unsigned wr_run = 0, rd_run = 0, overlap_cnt = 0, tie_cnt = 0;
  ev_t  evq[$];
  txn_t qa[$], qb[$];

  function automatic bit model_pick(bit a_pend, bit b_pend);
    if (a_pend && b_pend) return m_last_a;
    return b_pend;
  endfunction

  function automatic void model_serve(bit id, txn_t t);
    m_last_a = !id;
    if (t.we) ref_mem[t.addr] = t.data;
    else if (id) m_rdb = ref_mem[t.addr];
    else m_rda = ref_mem[t.addr];
    if (id) m_cnt_b = (m_cnt_b == 65535) ? 65535 : m_cnt_b + 1;
    else    m_cnt_a = (m_cnt_a == 65535) ? 65535 : m_cnt_a + 1;
  endfunction

  function automatic txn_t rand_txn(int unsigned lo, int unsigned hi);
    txn_t t;
    t.we   = 1'($urandom_range(0, 1));
    t.addr = AW'($urandom_range(hi, lo));
    t.data = DW'($urandom);
    return t;
  endfunction

  task automatic step();
    ev_t e;
    @(negedge clk);
    if (ram_cs_0 && ram_we_0) wr_run++;
    if (ram_cs_1 && ram_oe_1) rd_run++;
    if ((ram_cs_0 || ram_we_0) && (ram_cs_1 || ram_oe_1)) overlap_cnt++;
    if (ram_oe_0 || ram_we_1) tie_cnt++;
    if (ack_a || ack_b) begin
      e.id = ack_b; e.cyc = cyc; e.rda = rdata_a; e.rdb = rdata_b; e.wr = wr_run; e.rd = rd_run;
      evq.push_back(e);
      wr_run = 0;
      rd_run = 0;
    end
  endtask

  task automatic drive_heads();
    req_a = (qa.size() != 0);
    if (req_a) begin we_a = qa[0].we; addr_a = qa[0].addr; wdata_a = qa[0].data; end
    req_b = (qb.size() != 0);
    if (req_b) begin we_b = qb[0].we; addr_b = qb[0].addr; wdata_b = qb[0].data; end
  endtask

  // Presents both queues continuously (next transaction offered during HOLD) until all are acked
  task automatic run_queues(input int unsigned budget, output bit timeout, output int unsigned start);
    int unsigned n;
    int unsigned nev;
    step();
    evq.delete();
    wr_run = 0;
    rd_run = 0;
    timeout = 1'b0;
    start = cyc;
    n = 0;
    drive_heads();
    while (qa.size() + qb.size() != 0) begin
      nev = evq.size();
      step();
      for (int unsigned i = nev; i < evq.size(); i++) begin
        if (evq[i].id) begin if (qb.size() != 0) void'(qb.pop_front()); end
        else if (qa.size() != 0) void'(qa.pop_front());
      end
      drive_heads();
      n++;
      if (n > budget) begin timeout = 1'b1; break; end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    m_last_a = 1'b0; m_rda = '0; m_rdb = '0; m_cnt_a = 0; m_cnt_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_last_a = 1'b0; m_rda = '0; m_rdb = '0; m_cnt_a = 0; m_cnt_b = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack_a, ack_b, busy, ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_oe_1, ram_we_1} !== '0)
      $display("FAIL reset_ctrl: got %b expected 0",
               {ack_a, ack_b, busy, ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_oe_1, ram_we_1});
    else passed++;
    checks++;
    if ({rdata_a, rdata_b, ram_data_0, ram_address_0, ram_address_1} !== '0)
      $display("FAIL reset_data: got %h expected 0", {rdata_a, rdata_b, ram_data_0, ram_address_0, ram_address_1});
    else passed++;
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_write_read();
    txn_t t;
    bit to;
    int unsigned st;
    t.we = 1'b1; t.addr = 8'h10; t.data = 8'hA5;
    qa.delete(); qb.delete(); qa.push_back(t);
    run_queues(40, to, st);
    checks++;
    if (to || evq.size() != 1) $display("FAIL wr_done: got %0d acks expected 1 (timeout %0d)", evq.size(), to);
    else passed++;
    if (evq.size() == 1) begin
      checks++;
      if (evq[0].id !== 1'b0) $display("FAIL wr_ack_id: got %0d expected 0", evq[0].id); else passed++;
      checks++;
      if (evq[0].cyc - st !== WC + 2) $display("FAIL wr_latency: got %0d expected %0d", evq[0].cyc - st, WC + 2);
      else passed++;
      checks++;
      if (evq[0].wr !== WC || evq[0].rd !== 0)
        $display("FAIL wr_strobes: got wr=%0d rd=%0d expected wr=%0d rd=0", evq[0].wr, evq[0].rd, WC);
      else passed++;
    end
    model_serve(1'b0, t);
    t.we = 1'b0;
    qa.push_back(t);
    run_queues(40, to, st);
    checks++;
    if (to || evq.size() != 1) $display("FAIL rd_done: got %0d acks expected 1 (timeout %0d)", evq.size(), to);
    else passed++;
    if (evq.size() == 1) begin
      checks++;
      if (evq[0].cyc - st !== WC + 2) $display("FAIL rd_latency: got %0d expected %0d", evq[0].cyc - st, WC + 2);
      else passed++;
      checks++;
      if (evq[0].rd !== WC || evq[0].wr !== 0)
        $display("FAIL rd_strobes: got rd=%0d wr=%0d expected rd=%0d wr=0", evq[0].rd, evq[0].wr, WC);
      else passed++;
      checks++;
      if (evq[0].rda !== 8'hA5) $display("FAIL rd_data_a: got %h expected a5", evq[0].rda); else passed++;
    end
    model_serve(1'b0, t);
  endtask

  task automatic test_tie();
    txn_t ta, tb;
    bit to;
    int unsigned st;
    apply_reset();
    ta = rand_txn(8'h40, 8'h7F); ta.we = 1'b0;
    tb = rand_txn(8'h40, 8'h7F); tb.we = 1'b0;
    qa.delete(); qb.delete(); qa.push_back(ta); qb.push_back(tb);
    run_queues(60, to, st);
    checks++;
    if (to || evq.size() != 2) $display("FAIL tie_done: got %0d acks expected 2 (timeout %0d)", evq.size(), to);
    else passed++;
    model_serve(1'b0, ta);
    model_serve(1'b1, tb);
    if (evq.size() == 2) begin
      checks++;
      if (evq[0].id !== 1'b0 || evq[1].id !== 1'b1)
        $display("FAIL tie_order: got %0d,%0d expected 0,1", evq[0].id, evq[1].id);
      else passed++;
      checks++;
      if (evq[1].cyc - evq[0].cyc !== WC + 3)
        $display("FAIL tie_spacing: got %0d expected %0d", evq[1].cyc - evq[0].cyc, WC + 3);
      else passed++;
      checks++;
      if (evq[1].rda !== m_rda || evq[1].rdb !== m_rdb)
        $display("FAIL tie_rdata: got %h/%h expected %h/%h", evq[1].rda, evq[1].rdb, m_rda, m_rdb);
      else passed++;
    end
  endtask

  task automatic test_alternate();
    txn_t ea[$], eb[$];
    bit to;
    int unsigned st;
    overlap_cnt = 0;
    tie_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      ea.push_back(rand_txn(8'h40, 8'h7F));
      eb.push_back(rand_txn(8'h40, 8'h7F));
    end
    qa = ea; qb = eb;
    run_queues(100, to, st);
    checks++;
    if (to || evq.size() != 4) $display("FAIL alt_done: got %0d acks expected 4 (timeout %0d)", evq.size(), to);
    else passed++;
    for (int i = 0; i < evq.size() && i < 4; i++) begin
      checks++;
      if (evq[i].id !== 1'(i % 2)) $display("FAIL alt_order[%0d]: got %0d expected %0d", i, evq[i].id, i % 2);
      else passed++;
      if (i % 2 == 0) model_serve(1'b0, ea[i / 2]); else model_serve(1'b1, eb[i / 2]);
      checks++;
      if (evq[i].rda !== m_rda || evq[i].rdb !== m_rdb)
        $display("FAIL alt_rdata[%0d]: got %h/%h expected %h/%h", i, evq[i].rda, evq[i].rdb, m_rda, m_rdb);
      else passed++;
    end
    checks++;
    if (overlap_cnt !== 0) $display("FAIL alt_port_overlap: got %0d cycles expected 0", overlap_cnt); else passed++;
    checks++;
    if (tie_cnt !== 0) $display("FAIL alt_tied_pins: got %0d cycles expected 0", tie_cnt); else passed++;
  endtask

  task automatic test_read_isolation();
    txn_t t;
    txn_t eb[$];
    bit to;
    int unsigned st;
    t.we = 1'b0; t.addr = 8'h10; t.data = '0;
    qa.delete(); qb.delete(); qa.push_back(t);
    run_queues(40, to, st);
    model_serve(1'b0, t);
    checks++;
    if (rdata_a !== 8'hA5) $display("FAIL iso_pre_a: got %h expected a5", rdata_a); else passed++;
    t.we = 1'b1; t.addr = 8'h20; t.data = 8'h3C; eb.push_back(t);
    t.we = 1'b0; eb.push_back(t);
    t.we = 1'b1; t.data = 8'h77; eb.push_back(t);
    qb = eb;
    run_queues(80, to, st);
    checks++;
    if (to || evq.size() != 3) $display("FAIL iso_done: got %0d acks expected 3 (timeout %0d)", evq.size(), to);
    else passed++;
    foreach (eb[i]) model_serve(1'b1, eb[i]);
    if (evq.size() == 3) begin
      checks++;
      if (evq[1].rdb !== 8'h3C || evq[1].rda !== 8'hA5)
        $display("FAIL iso_read_b: got b=%h a=%h expected b=3c a=a5", evq[1].rdb, evq[1].rda);
      else passed++;
      checks++;
      if (evq[2].rdb !== 8'h3C || evq[2].rda !== 8'hA5)
        $display("FAIL iso_write_keeps: got b=%h a=%h expected b=3c a=a5", evq[2].rdb, evq[2].rda);
      else passed++;
    end
  endtask

  task automatic test_random_traffic();
    txn_t ea[$], eb[$];
    txn_t t;
    bit to, exp_id;
    int unsigned st, total, prev;
    overlap_cnt = 0;
    for (int r = 0; r < 8; r++) begin
      ea.delete(); eb.delete();
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) ea.push_back(rand_txn(0, 15));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) eb.push_back(rand_txn(0, 15));
      total = ea.size() + eb.size();
      qa = ea; qb = eb;
      run_queues(200, to, st);
      checks++;
      if (to || evq.size() != total)
        $display("FAIL rnd_done[%0d]: got %0d acks expected %0d (timeout %0d)", r, evq.size(), total, to);
      else passed++;
      prev = st - 1;
      for (int i = 0; i < evq.size() && (ea.size() + eb.size()) != 0; i++) begin
        exp_id = model_pick(ea.size() != 0, eb.size() != 0);
        t = exp_id ? eb.pop_front() : ea.pop_front();
        model_serve(exp_id, t);
        checks++;
        if (evq[i].id !== exp_id) $display("FAIL rnd_grant[%0d.%0d]: got %0d expected %0d", r, i, evq[i].id, exp_id);
        else passed++;
        checks++;
        if (evq[i].cyc - prev !== WC + 3)
          $display("FAIL rnd_timing[%0d.%0d]: got %0d expected %0d", r, i, evq[i].cyc - prev, WC + 3);
        else passed++;
        prev = evq[i].cyc;
        checks++;
        if (evq[i].rda !== m_rda || evq[i].rdb !== m_rdb)
          $display("FAIL rnd_rdata[%0d.%0d]: got %h/%h expected %h/%h", r, i, evq[i].rda, evq[i].rdb, m_rda, m_rdb);
        else passed++;
        checks++;
        if (evq[i].wr !== (t.we ? WC : 0) || evq[i].rd !== (t.we ? 0 : WC))
          $display("FAIL rnd_strobes[%0d.%0d]: got wr=%0d rd=%0d expected we=%0d for %0d cycles",
                   r, i, evq[i].wr, evq[i].rd, t.we, WC);
        else passed++;
      end
    end
    checks++;
    if (overlap_cnt !== 0) $display("FAIL rnd_port_overlap: got %0d cycles expected 0", overlap_cnt); else passed++;
  endtask

  task automatic test_reset_access();
    txn_t t;
    bit to;
    int unsigned st;
    step();
    we_a = 1'b0; addr_a = 8'h10; req_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ram_cs_1 !== 1'b1 || ram_oe_1 !== 1'b1)
      $display("FAIL rst_pre_strobe: got cs1=%b oe1=%b expected 1/1", ram_cs_1, ram_oe_1);
    else passed++;
    rst_n = 1'b0;
    req_a = 1'b0;
    m_last_a = 1'b0; m_rda = '0; m_rdb = '0; m_cnt_a = 0; m_cnt_b = 0;
    #1;
    checks++;
    if ({ram_cs_0, ram_we_0, ram_cs_1, ram_oe_1, ack_a, ack_b, busy} !== '0)
      $display("FAIL rst_async_ctrl: got %b expected 0", {ram_cs_0, ram_we_0, ram_cs_1, ram_oe_1, ack_a, ack_b, busy});
    else passed++;
    checks++;
    if (rdata_a !== '0 || rdata_b !== '0) $display("FAIL rst_rdata_clear: got %h/%h expected 0/0", rdata_a, rdata_b);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    evq.delete();
    repeat (8) step();
    checks++;
    if (evq.size() !== 0) $display("FAIL rst_no_ack: got %0d acks expected 0", evq.size()); else passed++;
    t.we = 1'b1; t.addr = 8'h30; t.data = DW'($urandom);
    qa.delete(); qb.delete(); qa.push_back(t);
    run_queues(40, to, st);
    model_serve(1'b0, t);
    checks++;
    if (to || evq.size() != 1 || evq[0].cyc - st !== WC + 2)
      $display("FAIL rst_recover_write: got %0d acks (timeout %0d) expected 1 at latency %0d", evq.size(), to, WC + 2);
    else passed++;
    t.we = 1'b0;
    qb.push_back(t);
    run_queues(40, to, st);
    model_serve(1'b1, t);
    checks++;
    if (rdata_b !== t.data) $display("FAIL rst_recover_read: got %h expected %h", rdata_b, t.data); else passed++;
  endtask

`ifdef RAM_ARB_STATS_EN
  task automatic test_stats();
    txn_t ea[$], eb[$];
    bit to, exp_id;
    int unsigned st;
    apply_reset();
    checks++;
    if (cnt_a !== 16'd0 || cnt_b !== 16'd0) $display("FAIL cnt_reset: got %0d/%0d expected 0/0", cnt_a, cnt_b);
    else passed++;
    for (int i = 0; i < 3; i++) ea.push_back(rand_txn(8'h80, 8'hFF));
    eb.push_back(rand_txn(8'h80, 8'hFF));
    qa = ea; qb = eb;
    run_queues(100, to, st);
    while (ea.size() + eb.size() != 0) begin
      exp_id = model_pick(ea.size() != 0, eb.size() != 0);
      if (exp_id) model_serve(1'b1, eb.pop_front()); else model_serve(1'b0, ea.pop_front());
    end
    checks++;
    if (cnt_a !== 16'(m_cnt_a) || cnt_b !== 16'(m_cnt_b))
      $display("FAIL cnt_count: got %0d/%0d expected %0d/%0d", cnt_a, cnt_b, m_cnt_a, m_cnt_b);
    else passed++;
    @(negedge clk);
    force dut.cnt_a_r = 16'hFFFE;
    @(negedge clk);
    release dut.cnt_a_r;
    m_cnt_a = 65534;
    for (int i = 0; i < 2; i++) ea.push_back(rand_txn(8'h80, 8'hFF));
    qa = ea;
    run_queues(100, to, st);
    while (ea.size() != 0) model_serve(1'b0, ea.pop_front());
    checks++;
    if (cnt_a !== 16'(m_cnt_a) || cnt_a !== 16'hFFFF)
      $display("FAIL cnt_saturate: got %h expected ffff", cnt_a);
    else passed++;
  endtask
`endif

  initial begin
    for (int unsigned i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    test_reset();
    test_write_read();
    test_tie();
    test_alternate();
    test_read_isolation();
    test_random_traffic();
    test_reset_access();
`ifdef RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
